// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with an optional 2-entry skid buffer and synchronous flush.
// Latency 1 cycle; with SKID_EN=1 in_ready is registered and never depends on out_ready.
module pipe_stage_skid #(
  parameter int unsigned       DATA_W    = 64,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter bit                SKID_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // Encoding is {main_v, skid_v}, so the valid flags are read straight off the state.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b10,
    ST_SKID  = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic [1:0]        occ_q, occ_d;
  logic              main_v, in_xfer, out_xfer;

  assign main_v    = state_q[1];
  assign in_ready  = SKID_EN ? in_ready_q : (!main_v || out_ready);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = main_v && out_ready;

  assign out_valid = main_v;
  assign out_data  = main_q;
  assign occupancy = occ_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (SKID_EN) begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d = ST_FULL;
            main_d  = in_data;
          end
        end
        ST_FULL: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end else if (in_xfer) begin
            state_d = ST_SKID;
            skid_d  = in_data;
          end
        end
        ST_SKID: begin
          if (out_xfer) begin
            state_d = ST_FULL;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end else begin
      if (in_xfer) begin
        state_d = ST_FULL;
        main_d  = in_data;
      end else if (out_xfer) begin
        state_d = ST_EMPTY;
      end
    end
    // Flush discards held entries and any transfer accepted this cycle.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = RESET_VAL;
    end
    in_ready_d = (state_d != ST_SKID);
    occ_d      = {1'b0, state_d[1]} + {1'b0, state_d[0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      main_q     <= RESET_VAL;
      skid_q     <= RESET_VAL;
      in_ready_q <= 1'b1;
      occ_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      occ_q      <= occ_d;
    end
  end

endmodule
